// File: rtl/speed_block_avg.sv
// speed_block_avg: multi-channel integrate-and-dump averager for the wind-speed path.
// One sample set per endata strobe is added into NCH accumulators, one channel per
// clock through a single shared adder. After 2^len sets the block is dumped as
// acc >>> len, with a one-clock douten pulse. Strobes that arrive while busy are
// dropped and flagged on smiss.
// Optional build macro: SPEED_BLOCK_AVG_ROUND_EN (round half up instead of
// truncating toward minus infinity at dump time).
module speed_block_avg #(
    parameter int NCH    = 2,
    parameter int DW     = 16,
    parameter int LENMIN = 6,
    parameter int LENMAX = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              endata,
    input  logic [NCH*DW-1:0] din,
    input  logic [3:0]        meanlen,
    output logic [NCH*DW-1:0] dout,
    output logic              douten,
    output logic              busy,
    output logic              smiss
);

    // LENMAX guard bits make a full block of extreme samples (plus the
    // rounding bias) fit without wrapping.
    localparam int AW = DW + LENMAX;
    localparam int KW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW = LENMAX;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DUMP
    } state_t;

    // Requested log2 length forced into the supported range.
    function automatic logic [3:0] clamp_len(input logic [3:0] m);
        if (int'(m) < LENMIN) begin
            return 4'(LENMIN);
        end else if (int'(m) > LENMAX) begin
            return 4'(LENMAX);
        end else begin
            return m;
        end
    endfunction

    state_t                 state_reg;
    state_t                 state_next;
    logic [KW-1:0]          k_reg;
    logic [CW-1:0]          count_reg;
    logic [3:0]             len_reg;
    logic signed [DW-1:0]   snap_reg [NCH];
    logic signed [AW-1:0]   acc_reg  [NCH];
    logic signed [DW-1:0]   dout_reg [NCH];
    logic                   douten_reg;
    logic                   smiss_reg;

    logic signed [DW-1:0]   din_ch   [NCH];
    logic signed [DW-1:0]   dump_val [NCH];
    logic signed [AW-1:0]   acc_sel;
    logic signed [DW-1:0]   snap_sel;
    logic signed [AW-1:0]   acc_sum;
    logic [CW-1:0]          count_limit;
    logic                   last_chan;
    logic                   block_done;

    // Per-channel unpacking of the input bus, dump arithmetic and output packing.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            logic signed [AW-1:0] biased_w;

            assign din_ch[gi] = din[gi*DW +: DW];

`ifdef SPEED_BLOCK_AVG_ROUND_EN
            // Adding half an LSB of the result before the floor shift gives
            // round-half-up; the guard bits keep this add from wrapping.
            assign biased_w = acc_reg[gi] + (AW'(1) << (len_reg - 4'd1));
`else
            assign biased_w = acc_reg[gi];
`endif

            // Average of DW-bit samples always fits back into DW bits.
            assign dump_val[gi] = DW'(biased_w >>> len_reg);
            assign dout[gi*DW +: DW] = dout_reg[gi];
        end
    endgenerate

    // Shared adder: the channel selected by k is the only one updated this clock.
    always_comb begin
        acc_sel     = acc_reg[k_reg];
        snap_sel    = snap_reg[k_reg];
        acc_sum     = acc_sel + {{LENMAX{snap_sel[DW-1]}}, snap_sel};
        // 2^len - 1 without overflowing CW bits when len == LENMAX.
        count_limit = ~({CW{1'b1}} << len_reg);
        last_chan   = (k_reg == KW'(NCH - 1));
        block_done  = (count_reg == count_limit);
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                if (endata) begin
                    state_next = ACC;
                end
            end
            ACC: begin
                if (last_chan) begin
                    state_next = block_done ? DUMP : IDLE;
                end
            end
            DUMP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Datapath: snapshot, accumulate, dump, and the one-clock status pulses.
    always_ff @(posedge clock) begin
        if (reset) begin
            k_reg      <= '0;
            count_reg  <= '0;
            len_reg    <= clamp_len(meanlen);
            douten_reg <= 1'b0;
            smiss_reg  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                acc_reg[i]  <= '0;
                snap_reg[i] <= '0;
                dout_reg[i] <= '0;
            end
        end else begin
            douten_reg <= (state_reg == DUMP);
            // Any strobe seen outside IDLE is dropped without touching the block.
            smiss_reg  <= endata && (state_reg != IDLE);
            unique case (state_reg)
                IDLE: begin
                    if (endata) begin
                        for (int i = 0; i < NCH; i++) begin
                            snap_reg[i] <= din_ch[i];
                        end
                        k_reg <= '0;
                    end
                end
                ACC: begin
                    acc_reg[k_reg] <= acc_sum;
                    if (!last_chan) begin
                        k_reg <= k_reg + KW'(1);
                    end else if (!block_done) begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                DUMP: begin
                    for (int i = 0; i < NCH; i++) begin
                        dout_reg[i] <= dump_val[i];
                        acc_reg[i]  <= '0;
                    end
                    count_reg <= '0;
                    k_reg     <= '0;
                    // A new length only ever applies from a block boundary.
                    len_reg   <= clamp_len(meanlen);
                end
                default: begin
                end
            endcase
        end
    end

    assign douten = douten_reg;
    assign smiss  = smiss_reg;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_speed_block_avg.sv
// Testbench for speed_block_avg: directed phases plus a randomized phase, all
// checked against a block-level averaging model (sums, sample counts, floor or
// rounded division, busy windows derived from the latency rules).
module tb_speed_block_avg;

    localparam int DW     = 16;
    localparam int NCH    = 2;
    localparam int NCH4   = 4;
    localparam int LENMIN = 6;
    localparam int LENMAX = 11;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                reset;
    logic                endata2;
    logic [NCH*DW-1:0]   din2;
    logic [3:0]          meanlen2;
    logic [NCH*DW-1:0]   dout2;
    logic                douten2, busy2, smiss2;

    logic                endata4;
    logic [NCH4*DW-1:0]  din4;
    logic [3:0]          meanlen4;
    logic [NCH4*DW-1:0]  dout4;
    logic                douten4, busy4, smiss4;

    speed_block_avg #(.NCH(NCH), .DW(DW), .LENMIN(LENMIN), .LENMAX(LENMAX)) dut2 (
        .clock(clock), .reset(reset), .endata(endata2), .din(din2), .meanlen(meanlen2),
        .dout(dout2), .douten(douten2), .busy(busy2), .smiss(smiss2)
    );

    speed_block_avg #(.NCH(NCH4), .DW(DW), .LENMIN(LENMIN), .LENMAX(LENMAX)) dut4 (
        .clock(clock), .reset(reset), .endata(endata4), .din(din4), .meanlen(meanlen4),
        .dout(dout4), .douten(douten4), .busy(busy4), .smiss(smiss4)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [63:0] d;
    } ev_t;

    // Observations gathered by the monitor.
    ev_t obs2[$];
    ev_t obs4[$];
    int  smiss2_cnt = 0, smiss4_cnt = 0, busy2_cnt = 0, dbl_cnt = 0;
    logic prev_douten2 = 1'b0, prev_smiss2 = 1'b0, prev_douten4 = 1'b0;

    always @(negedge clock) begin
        if (douten2 === 1'b1) obs2.push_back('{c: cyc, d: 64'(dout2)});
        if (douten4 === 1'b1) obs4.push_back('{c: cyc, d: dout4});
        if (smiss2 === 1'b1) smiss2_cnt++;
        if (smiss4 === 1'b1) smiss4_cnt++;
        if (busy2 === 1'b1) busy2_cnt++;
        if ((douten2 === 1'b1 && prev_douten2) || (smiss2 === 1'b1 && prev_smiss2) ||
            (douten4 === 1'b1 && prev_douten4)) dbl_cnt++;
        prev_douten2 = (douten2 === 1'b1);
        prev_smiss2  = (smiss2 === 1'b1);
        prev_douten4 = (douten4 === 1'b1);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference model for the NCH=2 instance.
    longint sum_m [NCH];
    int     n_m;
    int     len_m;
    int     busy_until;
    int     miss_exp = 0;
    int     busy_exp = 0;
    ev_t    exp2[$];

    function automatic int clampf(input int m);
        if (m < LENMIN) return LENMIN;
        if (m > LENMAX) return LENMAX;
        return m;
    endfunction

    function automatic longint avg_f(input longint s, input int len);
        longint d, x, q;
        d = longint'(1) << len;
        x = s;
`ifdef SPEED_BLOCK_AVG_ROUND_EN
        x = x + d / 2;
`endif
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) sum_m[k] = 0;
        n_m        = 0;
        len_m      = clampf(int'(meanlen2));
        busy_until = -1000;
    endtask

    task automatic model_strobe(input int t, input logic signed [DW-1:0] v0, input logic signed [DW-1:0] v1);
        ev_t    e;
        longint a;
        if (t > busy_until) begin
            sum_m[0] += longint'(v0);
            sum_m[1] += longint'(v1);
            n_m++;
            busy_exp += NCH;
            if (n_m == (1 << len_m)) begin
                e.c = t + NCH + 1;
                e.d = '0;
                for (int k = 0; k < NCH; k++) begin
                    a = avg_f(sum_m[k], len_m);
                    e.d[k*DW +: DW] = a[DW-1:0];
                    sum_m[k] = 0;
                end
                exp2.push_back(e);
                n_m        = 0;
                busy_until = t + NCH + 1;
                busy_exp   += 1;
                len_m      = clampf(int'(meanlen2));
            end else begin
                busy_until = t + NCH;
            end
        end else begin
            miss_exp++;
        end
    endtask

    task automatic strobe2(input logic signed [DW-1:0] v0, input logic signed [DW-1:0] v1, input int gap);
        int t;
        din2    = {v1, v0};
        endata2 = 1'b1;
        tick();
        endata2 = 1'b0;
        t = cyc;
        model_strobe(t, v0, v1);
        repeat (gap - 1) tick();
    endtask

    task automatic compare2(input string tag);
        ev_t o, e;
        repeat (8) tick();
        chk({tag, "_ndouten"}, obs2.size(), exp2.size());
        while (obs2.size() > 0 && exp2.size() > 0) begin
            o = obs2.pop_front();
            e = exp2.pop_front();
            chk({tag, "_cycle"}, o.c, e.c);
            for (int k = 0; k < NCH; k++)
                chk($sformatf("%s_ch%0d", tag, k), $signed(o.d[k*DW +: DW]), $signed(e.d[k*DW +: DW]));
        end
        obs2.delete();
        exp2.delete();
        chk({tag, "_smiss"}, smiss2_cnt, miss_exp);
        chk({tag, "_busy"}, busy2_cnt, busy_exp);
        chk({tag, "_onepulse"}, dbl_cnt, 0);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        tick();
        chk({tag, "_rst_dout"}, dout2, 0);
        chk({tag, "_rst_douten"}, douten2, 0);
        chk({tag, "_rst_busy"}, busy2, 0);
        chk({tag, "_rst_smiss"}, smiss2, 0);
        reset = 1'b0;
        tick();
        chk({tag, "_post_dout"}, dout2, 0);
        chk({tag, "_post_busy"}, busy2, 0);
        model_reset();
    endtask

    initial begin
        int t_a, t_b;
        ev_t o;
        logic signed [DW-1:0] r0, r1;

        reset    = 1'b1;
        endata2  = 1'b0;
        din2     = '0;
        meanlen2 = 4'd6;
        endata4  = 1'b0;
        din4     = '0;
        meanlen4 = 4'd11;
        repeat (3) tick();
        chk("init_dout4", dout4, 0);
        chk("init_busy4", busy4, 0);
        do_reset("init");

        // Constant mean, 64 strobes at 20-clock spacing.
        for (int i = 0; i < 64; i++) strobe2(16'sd1000, -16'sd1000, 20);
        chk("const_hold_ch0", $signed(dout2[15:0]), 1000);
        chk("const_hold_ch1", $signed(dout2[31:16]), -1000);
        compare2("const");

        // Clamp (3 -> 6) and mid-block length change taking effect next block.
        meanlen2 = 4'd3;
        do_reset("clamp");
        for (int i = 0; i < 192; i++) begin
            strobe2(16'(i * 37 - 1000), 16'(500 - i * 11), 20);
            if (i == 9) meanlen2 = 4'd7;
        end
        compare2("clamp_latch");
        meanlen2 = 4'd6;
        do_reset("len6");

        // Dropped strobe one clock after an accepted one.
        for (int i = 0; i < 64; i++) begin
            if (i == 5) begin
                strobe2(16'sd700, -16'sd300, 1);
                strobe2(16'sd30000, 16'sd30000, 19);
            end else begin
                strobe2(16'sd700, -16'sd300, 20);
            end
        end
        compare2("drop");

        // Rounding behaviour: 0/1 alternating and constant -1.
        for (int i = 0; i < 64; i++) strobe2(16'(i % 2), -16'sd1, 20);
        compare2("round");

        // Reset mid-block discards the partial sums.
        for (int i = 0; i < 40; i++) strobe2(16'($urandom), 16'($urandom), 20);
        do_reset("midrst");
        for (int i = 0; i < 64; i++) strobe2(16'sd500, 16'sd500, 20);
        compare2("midrst");

        // Random values and spacing, including strobes dropped while busy.
        for (int i = 0; i < 300; i++) begin
            r0 = 16'($urandom);
            r1 = 16'($urandom);
            strobe2(r0, r1, int'($urandom_range(2, 8)));
        end
        compare2("random");

        // Extremes on the four-channel instance at the maximum length.
        t_a = 0;
        t_b = 0;
        for (int i = 0; i < 4096; i++) begin
            din4    = (i < 2048) ? {4{16'h7FFF}} : {4{16'h8000}};
            endata4 = 1'b1;
            tick();
            endata4 = 1'b0;
            if (i == 2047) t_a = cyc;
            if (i == 4095) t_b = cyc;
            repeat (5) tick();
        end
        repeat (8) tick();
        chk("ext_ndouten", obs4.size(), 2);
        if (obs4.size() > 0) begin
            o = obs4.pop_front();
            chk("ext_pos_cycle", o.c, t_a + NCH4 + 1);
            for (int k = 0; k < NCH4; k++)
                chk($sformatf("ext_pos_ch%0d", k), $signed(o.d[k*DW +: DW]), 32767);
        end
        if (obs4.size() > 0) begin
            o = obs4.pop_front();
            chk("ext_neg_cycle", o.c, t_b + NCH4 + 1);
            for (int k = 0; k < NCH4; k++)
                chk($sformatf("ext_neg_ch%0d", k), $signed(o.d[k*DW +: DW]), -32768);
        end
        chk("ext_smiss", smiss4_cnt, 0);
        chk("ext_onepulse", dbl_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
